opcode_reader: RTL and testbench

Downstream neighbour of the program-counter stage in the CHIP-8 core. Samples the 16-bit program counter, performs two byte reads from the synchronous main RAM, assembles the big-endian 16-bit opcode and hands it to decode over a valid/ready handshake. Pulses `pc_advance` on each accepted opcode so the program-counter stage steps by 2. Supports flushing on branches and skips.

---
 rtl/opcode_reader.sv | 167 ++++++++++++++++
 tb/tb_opcode_reader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/opcode_reader.sv
`default_nettype none
// ============================================================================
// Module      : opcode_reader
// Description : CHIP-8 opcode fetch stage. Samples the program counter,
//               issues two byte reads to the synchronous RAM, and presents
//               the big-endian opcode {byte[pc], byte[pc+1]} to decode over
//               a valid/ready handshake. A one-cycle pc_advance pulse marks
//               each accepted opcode. flush abandons any fetch in progress.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in   core clock, rising edge
//   rst             in   asynchronous reset, active low
//   program_counter in   16-bit PC; only [ADDR_W-1:0] is used
//   flush           in   discard the in-flight fetch and return to IDLE
//   mem_rd_en       out  RAM read strobe
//   mem_addr        out  RAM byte address (0 while mem_rd_en is low)
//   mem_rdata       in   RAM data, valid the cycle after mem_rd_en
//   opcode          out  assembled opcode
//   opcode_valid    out  opcode held for decode
//   opcode_ready    in   decode accepts the opcode
//   pc_advance      out  one-cycle pulse on acceptance
//   align_fault     out  odd-PC fault indication
// Configuration
//   OPCODE_ALIGN_CHECK_EN : when defined, an odd PC parks the block in a
//                           FAULT state (align_fault=1) until flush/reset.
//                           When undefined, odd PCs are fetched normally and
//                           align_fault is tied low.
// ============================================================================
module opcode_reader #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       program_counter,
  input  logic              flush,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [15:0]       opcode,
  output logic              opcode_valid,
  input  logic              opcode_ready,
  output logic              pc_advance,
  output logic              align_fault
);

`ifdef OPCODE_ALIGN_CHECK_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ_HI  = 3'd1,
    S_REQ_LO  = 3'd2,
    S_CAPT_LO = 3'd3,
    S_VALID   = 3'd4,
    S_FAULT   = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ_HI  = 3'd1,
    S_REQ_LO  = 3'd2,
    S_CAPT_LO = 3'd3,
    S_VALID   = 3'd4
  } state_t;
`endif

  localparam logic [ADDR_W-1:0] C_ONE = ADDR_W'(1);

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_pc_q;
  logic [7:0]        r_hi;
  logic [15:0]       r_opcode;
  logic [ADDR_W-1:0] w_pc_plus1;
  logic              w_unused_pc_hi;

  // Upper PC bits lie outside the RAM address space and are deliberately dropped.
  assign w_unused_pc_hi = ^program_counter[15:ADDR_W];

  // Natural wrap of the ADDR_W-bit add gives 0xFFF+1 -> 0x000.
  assign w_pc_plus1 = r_pc_q + C_ONE;

  // opcode is a dedicated register loaded only when the low byte lands, so
  // decode never sees a half-updated value while the next fetch is running.
  assign opcode = r_opcode;

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    mem_rd_en    = 1'b0;
    mem_addr     = '0;
    opcode_valid = 1'b0;
    pc_advance   = 1'b0;
    align_fault  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!flush) begin
`ifdef OPCODE_ALIGN_CHECK_EN
          if (program_counter[0]) w_next_state = S_FAULT;
          else                    w_next_state = S_REQ_HI;
`else
          w_next_state = S_REQ_HI;
`endif
        end
      end
      S_REQ_HI: begin
        mem_rd_en    = 1'b1;
        mem_addr     = r_pc_q;
        w_next_state = S_REQ_LO;
      end
      S_REQ_LO: begin
        mem_rd_en    = 1'b1;
        mem_addr     = w_pc_plus1;
        w_next_state = S_CAPT_LO;
      end
      S_CAPT_LO: begin
        w_next_state = S_VALID;
      end
      S_VALID: begin
        opcode_valid = 1'b1;
        // flush outranks acceptance: a branch kills the opcode unadvanced.
        if (opcode_ready && !flush) begin
          pc_advance   = 1'b1;
          w_next_state = S_IDLE;
        end
      end
`ifdef OPCODE_ALIGN_CHECK_EN
      S_FAULT: begin
        align_fault = 1'b1;
      end
`endif
      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    if (flush) w_next_state = S_IDLE;
  end

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_pc_q   <= '0;
      r_hi     <= '0;
      r_opcode <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_IDLE && !flush) begin
        r_pc_q <= program_counter[ADDR_W-1:0];
      end
      // Read data arriving under flush belongs to an abandoned fetch.
      if (r_state == S_REQ_LO && !flush) begin
        r_hi <= mem_rdata;
      end
      if (r_state == S_CAPT_LO && !flush) begin
        r_opcode <= {r_hi, mem_rdata};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_opcode_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_opcode_reader
// Description : Directed scoreboard bench for opcode_reader. Stimulus pushes
//               expected read addresses and accepted opcodes into queues; a
//               negedge monitor pops and compares them as the DUT presents
//               reads and handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_opcode_reader;

  localparam int ADDR_W = 12;

  logic              clk;
  logic              rst;
  logic [15:0]       program_counter;
  logic              flush;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [15:0]       opcode;
  logic              opcode_valid;
  logic              opcode_ready;
  logic              pc_advance;
  logic              align_fault;

  int n_cmp = 0;
  int n_err = 0;
  int adv_count = 0;

  logic [ADDR_W-1:0] addr_q[$];
  logic [15:0]       op_q[$];
  logic [7:0]        ram [0:4095];

  opcode_reader #(.ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .program_counter (program_counter),
    .flush           (flush),
    .mem_rd_en       (mem_rd_en),
    .mem_addr        (mem_addr),
    .mem_rdata       (mem_rdata),
    .opcode          (opcode),
    .opcode_valid    (opcode_valid),
    .opcode_ready    (opcode_ready),
    .pc_advance      (pc_advance),
    .align_fault     (align_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: data one cycle after the strobe.
  initial mem_rdata = 8'h00;
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int lat;
    lat = 0;
    while (!opcode_valid && lat < 50) begin
      step();
      lat++;
    end
    check(name, lat, 4);
  endtask

  // Monitor: compares reads and accepted opcodes against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (mem_rd_en) begin
          if (addr_q.size() == 0) check("unexpected_read", {20'h0, mem_addr}, 32'hFFFF_FFFF);
          else                    check("rd_addr", {20'h0, mem_addr}, {20'h0, addr_q.pop_front()});
        end
        if (opcode_valid && opcode_ready && !flush) begin
          check("advance_on_accept", {31'h0, pc_advance}, 32'h1);
          if (op_q.size() == 0) check("unexpected_accept", {16'h0, opcode}, 32'hFFFF_FFFF);
          else                  check("opcode", {16'h0, opcode}, {16'h0, op_q.pop_front()});
        end else if (pc_advance) begin
          check("spurious_advance", {31'h0, pc_advance}, 32'h0);
        end
        if (pc_advance) adv_count++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int adv0;
    logic stable;

    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h200] = 8'h12; ram[12'h201] = 8'h34; ram[12'h202] = 8'h56;
    ram[12'hFFF] = 8'hAB; ram[12'h000] = 8'hCD;
    ram[12'h204] = 8'hAA; ram[12'h205] = 8'hBB;
    ram[12'h300] = 8'h6A; ram[12'h301] = 8'h0F;
    ram[12'h206] = 8'hD1; ram[12'h207] = 8'h23;

    rst = 1'b0; flush = 1'b0; opcode_ready = 1'b1;
    program_counter = 16'hF200;   // upper bits must be ignored
    step();
    step();
    check("reset_outputs",
          {opcode, opcode_valid, mem_rd_en, mem_addr, pc_advance, align_fault}, 32'h0);

    // ---- basic fetch at 0x200, ready tied high ----
    addr_q.push_back(12'h200); addr_q.push_back(12'h201); op_q.push_back(16'h1234);
    adv0 = adv_count;
    rst = 1'b1;
    wait_valid("latency_0x200");
    step();                                  // accepted; now IDLE
    opcode_ready = 1'b0;
    program_counter = 16'h0FFF;
    check("single_advance", adv_count - adv0, 1);

    // ---- address wrap 0xFFF -> 0x000 ----
    addr_q.push_back(12'hFFF); addr_q.push_back(12'h000); op_q.push_back(16'hABCD);
    wait_valid("latency_wrap");

    // ---- stall 20 cycles in VALID ----
    adv0 = adv_count;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!opcode_valid || opcode !== 16'hABCD) stable = 1'b0;
    end
    check("stall_hold", {31'h0, stable}, 32'h1);
    check("stall_no_advance", adv_count - adv0, 0);
    opcode_ready = 1'b1;
    program_counter = 16'h0204;
    step();                                  // accepted; now IDLE
    opcode_ready = 1'b0;
    check("stall_release_advance", adv_count - adv0, 1);

    // ---- flush during REQ_LO ----
    addr_q.push_back(12'h204); addr_q.push_back(12'h205);
    adv0 = adv_count;
    step();                                  // REQ_HI
    step();                                  // REQ_LO
    flush = 1'b1;
    program_counter = 16'h0300;
    step();                                  // IDLE after flush
    flush = 1'b0;
    check("flush_drops_valid", {31'h0, opcode_valid}, 32'h0);
    addr_q.push_back(12'h300); addr_q.push_back(12'h301);
    wait_valid("latency_after_flush");
    check("post_flush_opcode", {16'h0, opcode}, 32'h0000_6A0F);
    check("flush_no_advance", adv_count - adv0, 0);

    // ---- flush together with ready in VALID ----
    opcode_ready = 1'b1;
    flush = 1'b1;
    #2;
    check("flush_ready_adv", {31'h0, pc_advance}, 32'h0);
    step();                                  // IDLE
    check("flush_ready_valid_drop", {31'h0, opcode_valid}, 32'h0);
    flush = 1'b0; opcode_ready = 1'b0;
    program_counter = 16'h0200;

    // ---- asynchronous reset during CAPT_LO ----
    addr_q.push_back(12'h200); addr_q.push_back(12'h201);
    step();                                  // REQ_HI
    step();                                  // REQ_LO
    step();                                  // CAPT_LO
    rst = 1'b0;
    #1;
    check("async_reset_outputs",
          {opcode, opcode_valid, mem_rd_en, mem_addr, pc_advance, align_fault}, 32'h0);
    program_counter = 16'h0206;
    step();
    addr_q.push_back(12'h206); addr_q.push_back(12'h207); op_q.push_back(16'hD123);
    rst = 1'b1;
    wait_valid("latency_after_reset");
    opcode_ready = 1'b1;
    program_counter = 16'h0201;
    step();                                  // accepted; now IDLE
    opcode_ready = 1'b0;

    // ---- odd PC ----
`ifdef OPCODE_ALIGN_CHECK_EN
    step();
    step();
    check("align_fault_set", {30'h0, align_fault, opcode_valid}, 32'h2);
    step(); step(); step();
    check("align_fault_hold", {31'h0, align_fault}, 32'h1);
    flush = 1'b1;
    step();
    check("align_fault_cleared", {31'h0, align_fault}, 32'h0);
`else
    addr_q.push_back(12'h201); addr_q.push_back(12'h202); op_q.push_back(16'h3456);
    wait_valid("latency_odd_pc");
    check("no_align_fault", {31'h0, align_fault}, 32'h0);
    opcode_ready = 1'b1;
    step();                                  // accepted; now IDLE
    opcode_ready = 1'b0;
    flush = 1'b1;                            // park in IDLE
`endif

    step(); step(); step();
    check("addr_queue_drained", addr_q.size(), 0);
    check("opcode_queue_drained", op_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
